// File: rtl/scan_chain_ctrl_pkg.sv
// Shared types and limits for the scan chain sequencer.
// The limits are used by elaboration-time parameter checks in the top.
package scan_chain_ctrl_pkg;

  localparam int SCAN_MAX_CHAIN   = 256;
  localparam int SCAN_MAX_CAPTURE = 15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_IN = 3'd1,
    CAPTURE  = 3'd2,
    UNLOAD   = 3'd3,
    DONE     = 3'd4
  } scan_state_e;

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// Host-side request/result signals plus the chain head/tail connection.
// The master modport is the test host and chain; slave is the sequencer.
interface scan_chain_ctrl_if #(
  parameter int CHAIN_LEN = 8
);

  logic                 start;
  logic                 abort;
  logic [CHAIN_LEN-1:0] pattern_in;
  logic [CHAIN_LEN-1:0] expect_in;
  logic                 scan_out;
  logic                 scan_enable;
  logic                 scan_in;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] unload_data;
  logic                 mismatch;

  modport master (
    output start, abort, pattern_in, expect_in, scan_out,
    input  scan_enable, scan_in, busy, done, unload_data, mismatch
  );

  modport slave (
    input  start, abort, pattern_in, expect_in, scan_out,
    output scan_enable, scan_in, busy, done, unload_data, mismatch
  );

endinterface

// File: rtl/scan_chain_ctrl_shift_reg.sv
// Parallel-load, shift-left register with serial in at bit 0 and serial out
// from the MSB; used for both the load shadow and the unload shadow.
module scan_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data,
  output logic             serial_out
);

  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= load_data;
    end else if (shift) begin
      data_reg <= {data_reg[WIDTH-2:0], serial_in};
    end
  end

  assign data       = data_reg;
  assign serial_out = data_reg[WIDTH-1];

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shift a pattern in, run functional capture clocks,
// shift the captured state out and compare it with the expected vector.
module scan_chain_ctrl
  import scan_chain_ctrl_pkg::*;
#(
  parameter  int CHAIN_LEN      = 8,
  parameter  int CAPTURE_CYCLES = 1,
  localparam int CNT_W          = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  scan_chain_ctrl_if.slave  bus
);

  // The same counter also times the capture phase, so it must hold 15.
  localparam int CTR_W = (CNT_W > 4) ? CNT_W : 4;

  if (CHAIN_LEN < 2 || CHAIN_LEN > SCAN_MAX_CHAIN) begin : g_bad_chain_len
    $error("scan_chain_ctrl: CHAIN_LEN out of range");
  end
  if (CAPTURE_CYCLES < 1 || CAPTURE_CYCLES > SCAN_MAX_CAPTURE) begin : g_bad_capture
    $error("scan_chain_ctrl: CAPTURE_CYCLES out of range");
  end

  scan_state_e          state_reg;
  logic [CTR_W-1:0]     cnt_reg;
  logic                 scan_enable_reg;
  logic                 scan_in_reg;
  logic [CHAIN_LEN-1:0] expect_reg;
  logic [CHAIN_LEN-1:0] unload_data_reg;
  logic                 mismatch_reg;

  logic                 start_accept;
  logic                 abort_hit;
  logic                 load_serial_out;
  logic [CHAIN_LEN-1:0] load_data_unused;
  logic [CHAIN_LEN-1:0] unload_shadow;
  logic                 unload_serial_unused;
  logic [CHAIN_LEN-1:0] unload_next;

  assign start_accept = (state_reg == IDLE) && bus.start;
  assign abort_hit    = (state_reg != IDLE) && bus.abort;

  // The MSB goes straight to scan_in on the start edge, so the shadow is
  // loaded pre-shifted and its serial out always holds the next bit to send.
  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_load_shadow (
    .clk        (clk),
    .rstn       (rstn),
    .load       (start_accept),
    .shift      ((state_reg == SHIFT_IN) && !abort_hit),
    .load_data  ({bus.pattern_in[CHAIN_LEN-2:0], 1'b0}),
    .serial_in  (1'b0),
    .data       (load_data_unused),
    .serial_out (load_serial_out)
  );

  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_unload_shadow (
    .clk        (clk),
    .rstn       (rstn),
    .load       (1'b0),
    .shift      ((state_reg == UNLOAD) && !abort_hit),
    .load_data  ('0),
    .serial_in  (bus.scan_out),
    .data       (unload_shadow),
    .serial_out (unload_serial_unused)
  );

  // Value the unload shadow takes on the final unload edge.
  assign unload_next = {unload_shadow[CHAIN_LEN-2:0], bus.scan_out};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      scan_enable_reg <= 1'b0;
      scan_in_reg     <= 1'b0;
      expect_reg      <= '0;
      unload_data_reg <= '0;
      mismatch_reg    <= 1'b0;
    end else if (abort_hit) begin
      state_reg       <= IDLE;
      scan_enable_reg <= 1'b0;
      scan_in_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            expect_reg      <= bus.expect_in;
            cnt_reg         <= CTR_W'(CHAIN_LEN);
            scan_enable_reg <= 1'b1;
            scan_in_reg     <= bus.pattern_in[CHAIN_LEN-1];
            state_reg       <= SHIFT_IN;
          end
        end
        SHIFT_IN: begin
          if (cnt_reg == CTR_W'(1)) begin
            scan_enable_reg <= 1'b0;
            scan_in_reg     <= 1'b0;
            cnt_reg         <= CTR_W'(CAPTURE_CYCLES);
            state_reg       <= CAPTURE;
          end else begin
            scan_in_reg <= load_serial_out;
            cnt_reg     <= cnt_reg - CTR_W'(1);
          end
        end
        CAPTURE: begin
          if (cnt_reg == CTR_W'(1)) begin
            scan_enable_reg <= 1'b1;
            cnt_reg         <= CTR_W'(CHAIN_LEN);
            state_reg       <= UNLOAD;
          end else begin
            cnt_reg <= cnt_reg - CTR_W'(1);
          end
        end
        UNLOAD: begin
          cnt_reg <= cnt_reg - CTR_W'(1);
          if (cnt_reg == CTR_W'(1)) begin
            scan_enable_reg <= 1'b0;
            unload_data_reg <= unload_next;
            mismatch_reg    <= |(unload_next ^ expect_reg);
            state_reg       <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.scan_enable = scan_enable_reg;
  assign bus.scan_in     = scan_in_reg;
  assign bus.busy        = (state_reg == SHIFT_IN) || (state_reg == CAPTURE) ||
                           (state_reg == UNLOAD);
  assign bus.done        = (state_reg == DONE);
  assign bus.unload_data = unload_data_reg;
  assign bus.mismatch    = mismatch_reg;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two instances (1 and 2 capture clocks), each
// driving an 8-flop mux-D chain whose functional D is ~Q.
module tb_scan_chain_ctrl;

  localparam int N = 8;

  typedef struct packed {
    logic         se;
    logic         si;
    logic         busy;
    logic         done;
    logic         mm;
    logic [N-1:0] ud;
  } obs_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  scan_chain_ctrl_if #(.CHAIN_LEN(N)) bus1 ();
  scan_chain_ctrl_if #(.CHAIN_LEN(N)) bus2 ();

  scan_chain_ctrl #(.CHAIN_LEN(N), .CAPTURE_CYCLES(1)) dut1 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus1)
  );

  scan_chain_ctrl #(.CHAIN_LEN(N), .CAPTURE_CYCLES(2)) dut2 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus2)
  );

  // Scannable flops: flop 0 is the head, flop N-1 feeds scan_out.
  logic [N-1:0] chain1, chain2;
  always @(posedge clk) begin
    if (bus1.scan_enable) chain1 <= {chain1[N-2:0], bus1.scan_in};
    else                  chain1 <= ~chain1;
    if (bus2.scan_enable) chain2 <= {chain2[N-2:0], bus2.scan_in};
    else                  chain2 <= ~chain2;
  end
  assign bus1.scan_out = chain1[N-1];
  assign bus2.scan_out = chain2[N-1];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: last completed result per instance and capture count.
  logic [N-1:0] model_ud [1:2];
  logic         model_mm [1:2];
  int           capt     [1:2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input int which, input logic st, input logic ab,
                        input logic [N-1:0] p, input logic [N-1:0] e);
    if (which == 2) begin
      bus2.start = st; bus2.abort = ab; bus2.pattern_in = p; bus2.expect_in = e;
    end else begin
      bus1.start = st; bus1.abort = ab; bus1.pattern_in = p; bus1.expect_in = e;
    end
  endtask

  function automatic obs_t sample(input int which);
    obs_t o;
    if (which == 2) begin
      o.se = bus2.scan_enable; o.si = bus2.scan_in; o.busy = bus2.busy;
      o.done = bus2.done; o.mm = bus2.mismatch; o.ud = bus2.unload_data;
    end else begin
      o.se = bus1.scan_enable; o.si = bus1.scan_in; o.busy = bus1.busy;
      o.done = bus1.done; o.mm = bus1.mismatch; o.ud = bus1.unload_data;
    end
    return o;
  endfunction

  function automatic logic [N-1:0] chain_of(input int which);
    return (which == 2) ? chain2 : chain1;
  endfunction

  // One start request; cycle k is the k-th cycle after the start-sample edge.
  task automatic run(input int which, input logic [N-1:0] pat, input logic [N-1:0] exv,
                     input int abort_at, input int rst_at, input bit busy_start);
    int           c;
    int           total;
    logic [N-1:0] exp_ud;
    logic [31:0]  se_obs, se_exp, busy_obs, busy_exp, done_obs, done_exp;
    obs_t         o;
    c      = capt[which];
    total  = 2 * N + c;
    // Each capture clock inverts every flop once.
    exp_ud = (c % 2 == 1) ? ~pat : pat;
    se_obs = '0; se_exp = '0; busy_obs = '0; busy_exp = '0; done_obs = '0; done_exp = '0;
    @(negedge clk);
    set_in(which, 1'b1, 1'b0, pat, exv);
    @(posedge clk);
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      o = sample(which);
      set_in(which, busy_start && (k == 5), (abort_at != 0) && (k == abort_at), ~pat, ~exv);
      if (abort_at != 0 && k == abort_at + 1) begin
        check("abort_outputs", 32'({o.se, o.si, o.busy, o.done}), 32'd0);
        check("abort_ud_held", 32'(o.ud), 32'(model_ud[which]));
        check("abort_mm_held", 32'(o.mm), 32'(model_mm[which]));
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          o = sample(which);
          check("abort_no_done", 32'({o.busy, o.done}), 32'd0);
        end
        return;
      end
      if (rst_at != 0 && k == rst_at) begin
        #1 rstn = 1'b0;
        #1 o = sample(which);
        check("async_reset", 32'(o), 32'd0);
        model_ud[1] = '0; model_mm[1] = 1'b0;
        model_ud[2] = '0; model_mm[2] = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
      se_obs[k]   = o.se;
      busy_obs[k] = o.busy;
      done_obs[k] = o.done;
      se_exp[k]   = (k <= N) || (k > N + c && k <= total);
      busy_exp[k] = (k <= total);
      done_exp[k] = (k == total + 1);
      if (k == N + 1) check("chain_loaded", 32'(chain_of(which)), 32'(pat));
      if (k == total + 1) begin
        check("unload_data", 32'(o.ud), 32'(exp_ud));
        check("mismatch", 32'(o.mm), 32'(exp_ud != exv));
      end
    end
    check("scan_enable_profile", se_obs, se_exp);
    check("busy_profile", busy_obs, busy_exp);
    check("done_profile", done_obs, done_exp);
    model_ud[which] = exp_ud;
    model_mm[which] = (exp_ud != exv);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      o = sample(which);
      check("post_done_idle", 32'({o.busy, o.done, o.se}), 32'd0);
    end
    $display("run dut%0d pattern=%02h expect=%02h unload=%02h mismatch=%0b", which, pat, exv,
             o.ud, o.mm);
  endtask

  initial begin
    obs_t         o;
    logic [N-1:0] p, e;
    capt[1] = 1; capt[2] = 2;
    model_ud[1] = '0; model_mm[1] = 1'b0;
    model_ud[2] = '0; model_mm[2] = 1'b0;
    set_in(1, 1'b0, 1'b0, '0, '0);
    set_in(2, 1'b0, 1'b0, '0, '0);

    // Held in reset while start toggles: nothing may move.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_in(1, k[0], 1'b0, 8'hA5, 8'h5A);
      o = sample(1);
      check("reset_outputs", 32'(o), 32'd0);
    end
    @(negedge clk);
    set_in(1, 1'b0, 1'b0, '0, '0);
    rstn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      o = sample(1);
      check("idle_after_reset", 32'(o), 32'd0);
    end

    run(1, 8'hA5, 8'h5A, 0, 0, 1'b0);
    run(1, 8'hA5, 8'h5B, 0, 0, 1'b0);
    run(2, 8'h0F, 8'h0F, 0, 0, 1'b0);

    // abort while idle changes nothing
    @(negedge clk);
    set_in(1, 1'b0, 1'b1, '0, '0);
    @(negedge clk);
    o = sample(1);
    set_in(1, 1'b0, 1'b0, '0, '0);
    check("idle_abort", 32'({o.busy, o.done, o.mm, o.ud}), 32'({3'b001, model_ud[1]}));

    run(1, 8'h77, 8'h88, 4, 0, 1'b0);
    run(1, 8'h3C, 8'hC3, 0, 0, 1'b1);
    run(1, 8'h96, 8'h69, 0, N + 1 + 3, 1'b0);
    run(1, 8'h5A, 8'hA5, 0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      p = N'($urandom);
      e = (r % 2 == 0) ? ((r % 4 == 0) ? ~p : p) : (N'($urandom));
      run((r % 3 == 2) ? 2 : 1, p, e, 0, 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
